// File: rtl/bgr_pkg.sv
// Shared types and sizing helpers for the bandgap startup controller.
package bgr_pkg;

  localparam int KICK_CYCLES_DEF   = 64;
  localparam int SETTLE_CYCLES_DEF = 1024;
  localparam int DEBOUNCE_DEF      = 16;
  localparam int MAX_RETRY_DEF     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KICK   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAULT  = 3'd5
  } bgr_state_t;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous vbg-good comparator output.
// Both stages clear to 0 under reset so a stale "good" can never leak through.
module bgr_sync2
  import bgr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap startup/supervision FSM: kicks the core via porst, waits, checks the
// debounced vbg-good, retries a bounded number of times and re-kicks on brownout.
module bgr_startup_ctrl
  import bgr_pkg::*;
#(
  parameter int KICK_CYCLES   = KICK_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DEBOUNCE      = DEBOUNCE_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          vbg_ok_async,
  output logic                          porst,
  output logic                          bgr_ready,
  output logic                          bgr_fault,
  output logic [cnt_w(MAX_RETRY)-1:0]   retry_cnt
);

  localparam int PH_W = cnt_w(max2(KICK_CYCLES, SETTLE_CYCLES));
  localparam int DB_W = cnt_w(DEBOUNCE);
  localparam int RT_W = cnt_w(MAX_RETRY);

  localparam logic [PH_W-1:0] KICK_LAST   = PH_W'(KICK_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_TGT      = DB_W'(DEBOUNCE);
  localparam logic [RT_W-1:0] RT_MAX      = RT_W'(MAX_RETRY);

  logic ok_s;

  bgr_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vbg_ok_async),
    .q     (ok_s)
  );

  bgr_state_t      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [DB_W-1:0] dbnc_q, dbnc_d;
  logic [DB_W-1:0] dbnc_inc;
  logic [RT_W-1:0] retry_q, retry_d;
  logic            porst_q, porst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dbnc_d   = dbnc_q;
    retry_d  = retry_q;
    porst_d  = 1'b0;
    dbnc_inc = (dbnc_q == DB_TGT) ? dbnc_q : dbnc_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        dbnc_d  = '0;
        retry_d = '0;
        if (en) state_d = ST_KICK;
      end
      ST_KICK: begin
        porst_d = 1'b1;
        if (phase_q == KICK_LAST) begin
          state_d = ST_SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          phase_d = '0;
          dbnc_d  = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CHECK: begin
        dbnc_d = ok_s ? dbnc_inc : '0;
        // Debounce completion is tested first so it wins over a same-cycle timeout.
        if (ok_s && (dbnc_inc == DB_TGT)) begin
          state_d = ST_READY;
          phase_d = '0;
          dbnc_d  = '0;
        end else if (phase_q == SETTLE_LAST) begin
          phase_d = '0;
          dbnc_d  = '0;
          if (retry_q < RT_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_KICK;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_READY: begin
        dbnc_d = ok_s ? '0 : dbnc_inc;
        // Brownout raises porst on the detecting edge, together with the ready drop;
        // the kick phase starts at 1 so the pulse still lasts KICK_CYCLES.
        if (!ok_s && (dbnc_inc == DB_TGT)) begin
          porst_d = 1'b1;
          retry_d = '0;
          dbnc_d  = '0;
          if (KICK_CYCLES > 1) begin
            state_d = ST_KICK;
            phase_d = PH_W'(1);
          end else begin
            state_d = ST_SETTLE;
            phase_d = '0;
          end
        end
      end
      ST_FAULT: begin
        phase_d = '0;
        dbnc_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_d = ST_IDLE;
      phase_d = '0;
      dbnc_d  = '0;
      retry_d = '0;
      porst_d = 1'b0;
    end

    ready_d = (state_d == ST_READY);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      dbnc_q  <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dbnc_q  <= dbnc_d;
      retry_q <= retry_d;
      porst_q <= porst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign bgr_fault = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed bench for bgr_startup_ctrl with K=4, S=8, D=3, MAX_RETRY=2.
// Cycle c means "just after the c-th rising edge, counting the edge that first samples en=1 as 0".
module tb_bgr_startup_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       vbg_ok_async = 1'b0;
  logic       porst;
  logic       bgr_ready;
  logic       bgr_fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bgr_startup_ctrl #(
    .KICK_CYCLES   (4),
    .SETTLE_CYCLES (8),
    .DEBOUNCE      (3),
    .MAX_RETRY     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .vbg_ok_async (vbg_ok_async),
    .porst        (porst),
    .bgr_ready    (bgr_ready),
    .bgr_fault    (bgr_fault),
    .retry_cnt    (retry_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({porst, bgr_ready, bgr_fault, retry_cnt} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold c=%0d got %b%b%b%b want 00000", c, porst, bgr_ready, bgr_fault, retry_cnt);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({porst, bgr_ready, bgr_fault, retry_cnt} !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got %b%b%b%b want 00000", c, porst, bgr_ready, bgr_fault, retry_cnt);
      end
    end
  endtask

  task automatic test_nominal();
    logic ep, er;
    vbg_ok_async = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    en = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      ep = (c >= 1 && c <= 4);
      er = (c >= 15);
      checks++;
      if (porst !== ep || bgr_ready !== er || bgr_fault !== 1'b0 || retry_cnt !== 2'd0) begin
        errors++;
        $display("FAIL nominal c=%0d got porst=%b rdy=%b flt=%b rty=%0d want porst=%b rdy=%b flt=0 rty=0",
                 c, porst, bgr_ready, bgr_fault, retry_cnt, ep, er);
      end
    end
  endtask

  task automatic test_brownout();
    logic ep, er;
    vbg_ok_async = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (bgr_ready !== 1'b1 || porst !== 1'b0) begin
        errors++;
        $display("FAIL short_drop c=%0d got rdy=%b porst=%b want rdy=1 porst=0", c, bgr_ready, porst);
      end
      if (c == 2) vbg_ok_async = 1'b1;
    end
    vbg_ok_async = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      tick();
      er = (c < 5) || (c >= 19);
      ep = (c >= 5 && c <= 8);
      checks++;
      if (bgr_ready !== er || porst !== ep || retry_cnt !== 2'd0 || bgr_fault !== 1'b0) begin
        errors++;
        $display("FAIL brownout c=%0d got rdy=%b porst=%b rty=%0d flt=%b want rdy=%b porst=%b rty=0 flt=0",
                 c, bgr_ready, porst, retry_cnt, bgr_fault, er, ep);
      end
      if (c == 3) vbg_ok_async = 1'b1;
    end
    en = 1'b0;
    tick();
    checks++;
    if ({porst, bgr_ready, bgr_fault, retry_cnt} !== 5'b0) begin
      errors++;
      $display("FAIL disable_ready got %b%b%b%b want 00000", porst, bgr_ready, bgr_fault, retry_cnt);
    end
  endtask

  task automatic test_dead_core();
    logic       ep, ef;
    logic [1:0] et;
    vbg_ok_async = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    en = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      tick();
      ep = (c >= 1 && c <= 4) || (c >= 21 && c <= 24) || (c >= 41 && c <= 44);
      et = (c < 20) ? 2'd0 : (c < 40) ? 2'd1 : 2'd2;
      ef = (c >= 60);
      checks++;
      if (porst !== ep || retry_cnt !== et || bgr_fault !== ef || bgr_ready !== 1'b0) begin
        errors++;
        $display("FAIL dead_core c=%0d got porst=%b rty=%0d flt=%b rdy=%b want porst=%b rty=%0d flt=%b rdy=0",
                 c, porst, retry_cnt, bgr_fault, bgr_ready, ep, et, ef);
      end
    end
  endtask

  task automatic test_fault_clear();
    en = 1'b0;
    tick();
    checks++;
    if (bgr_fault !== 1'b0 || retry_cnt !== 2'd0 || porst !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got flt=%b rty=%0d porst=%b want 0 0 0", bgr_fault, retry_cnt, porst);
    end
    en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      checks++;
      if (porst !== (c >= 1 && c <= 4) || retry_cnt !== 2'd0 || bgr_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_rekick c=%0d got porst=%b rty=%0d flt=%b want porst=%b rty=0 flt=0",
                 c, porst, retry_cnt, bgr_fault, (c >= 1 && c <= 4));
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    logic ep;
    logic [1:0] et;
    vbg_ok_async = 1'b0;
    tick();
    en = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      tick();
      ep = (c >= 1 && c <= 4) || (c == 21);
      et = (c >= 20) ? 2'd1 : 2'd0;
      checks++;
      if (bgr_ready !== 1'b0 || porst !== ep || retry_cnt !== et) begin
        errors++;
        $display("FAIL glitch c=%0d got rdy=%b porst=%b rty=%0d want rdy=0 porst=%b rty=%0d",
                 c, bgr_ready, porst, retry_cnt, ep, et);
      end
      if (c == 12) vbg_ok_async = 1'b1;
      if (c == 14) vbg_ok_async = 1'b0;
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    en = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      tick();
      checks++;
      if (porst !== (c == 1 || c == 2)) begin
        errors++;
        $display("FAIL abort c=%0d got porst=%b want %b", c, porst, (c == 1 || c == 2));
      end
      if (c == 2) en = 1'b0;
    end
    en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      checks++;
      if (porst !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL restart c=%0d got porst=%b want %b", c, porst, (c >= 1 && c <= 4));
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    vbg_ok_async = 1'b0;
    en = 1'b1;
    for (int c = 0; c <= 27; c++) tick();
    checks++;
    if (retry_cnt !== 2'd1 || porst !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got rty=%0d porst=%b want rty=1 porst=0", retry_cnt, porst);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({porst, bgr_ready, bgr_fault, retry_cnt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_settle got %b%b%b%b want 00000", porst, bgr_ready, bgr_fault, retry_cnt);
    end
    rst_n = 1'b1;
    for (int c = 0; c <= 2; c++) tick();
    checks++;
    if (porst !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_kick got porst=%b want 1", porst);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (porst !== 1'b0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_kick got porst=%b rty=%0d want 0 0", porst, retry_cnt);
    end
    en = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_brownout();
    test_dead_core();
    test_fault_clear();
    test_glitch();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
